// File: rtl/kbd_seq_encoder_if.sv
// Byte-stream bundle between a keyboard source and the sequence encoder.
// The key side and the UART-facing handshake travel together.
interface kbd_seq_encoder_if;
  logic [7:0] usb_kbd;
  logic       kbd_strobe;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       overflow;

  modport master (
    output usb_kbd,
    output kbd_strobe,
    output ready,
    input  data,
    input  valid,
    input  overflow
  );

  modport slave (
    input  usb_kbd,
    input  kbd_strobe,
    input  ready,
    output data,
    output valid,
    output overflow
  );
endinterface

// File: rtl/kbd_seq_encoder.sv
// Keyboard code to terminal byte-sequence encoder: edge-detected key events
// feed a FIFO, and a small sequencer expands special keys into ESC pairs.
module kbd_seq_encoder #(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  kbd_seq_encoder_if.slave  kbd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND_ESC,
    SEND_LAST
  } state_t;

  state_t          state_reg, state_next;
  logic            strobe_reg;
  logic [7:0]      fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic [7:0]      second_reg, second_next;
  logic            overflow_reg;

  logic            key_event;
  logic            code_ok;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            drop;
  logic            pop;
  logic [7:0]      head;
  logic [7:0]      head_second;
  logic            handshake;

  assign key_event  = kbd.kbd_strobe & ~strobe_reg;
  // Codes 0x88..0xFF have bit 7 set and something in bits 6:3.
  assign code_ok    = ~(kbd.usb_kbd[7] & (|kbd.usb_kbd[6:3]));
  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  // Fullness is judged on the pre-pop count, so a same-cycle pop never helps.
  assign push       = key_event & code_ok & ~fifo_full;
  assign drop       = key_event & code_ok & fifo_full;
  assign handshake  = valid_reg & kbd.ready;

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_second = head[2] ? (8'h50 + {6'd0, head[1:0]})
                               : (8'h41 + {6'd0, head[1:0]});

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    valid_next  = valid_reg;
    second_next = second_reg;
    pop         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      SEND_ESC: begin
        if (handshake) begin
          data_next  = second_reg;
          state_next = SEND_LAST;
        end
      end
      SEND_LAST: begin
        if (handshake) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase

    // Loading a fresh entry is shared by IDLE and the back-to-back SEND_LAST path.
    if (pop) begin
      valid_next = 1'b1;
      if (head[7]) begin
        data_next   = 8'h1B;
        second_next = head_second;
        state_next  = SEND_ESC;
      end else begin
        data_next  = head;
        state_next = SEND_LAST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr_reg] <= kbd.usb_kbd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      strobe_reg   <= 1'b1;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_reg     <= 8'h00;
      valid_reg    <= 1'b0;
      second_reg   <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      strobe_reg   <= kbd.kbd_strobe;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      second_reg   <= second_next;
      overflow_reg <= drop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign kbd.data     = data_reg;
  assign kbd.valid    = valid_reg;
  assign kbd.overflow = overflow_reg;

endmodule

// File: tb/tb_kbd_seq_encoder.sv
// Self-checking bench for kbd_seq_encoder: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_kbd_seq_encoder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  kbd_seq_encoder_if kif ();

  kbd_seq_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .kbd   (kif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ovf_count = 0;
  int vcount = 0;

  // Reference model state: pending keys, bytes of the key being sent.
  logic [7:0] m_fifo [$];
  logic [7:0] cur [$];
  logic       m_strobe = 1'b1;
  logic       exp_ovf = 1'b0;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  logic [7:0] second_tab [0:7] = '{8'h41, 8'h42, 8'h43, 8'h44,
                                   8'h50, 8'h51, 8'h52, 8'h53};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void expand(input logic [7:0] k);
    if (k < 8'h80) begin
      cur.push_back(k);
    end else begin
      cur.push_back(8'h1B);
      cur.push_back(second_tab[k[2:0]]);
    end
  endfunction

  task automatic step(input logic s, input logic [7:0] k, input logic r);
    int  pre;
    logic evt;
    logic popped;
    logic [7:0] k0;
    if (kif.valid && r) begin
      got.push_back(kif.data);
      $display("tx byte=%02h at %0t", kif.data, $time);
    end
    kif.kbd_strobe = s;
    kif.usb_kbd    = k;
    kif.ready      = r;

    pre      = m_fifo.size();
    evt      = s && !m_strobe;
    m_strobe = s;
    exp_ovf  = 1'b0;
    popped   = 1'b0;
    if (cur.size() == 0) begin
      if (pre != 0) popped = 1'b1;
    end else if (r) begin
      void'(cur.pop_front());
      if (cur.size() == 0 && pre != 0) popped = 1'b1;
    end
    if (popped) begin
      k0 = m_fifo.pop_front();
      expand(k0);
    end
    if (evt && k < 8'h88) begin
      if (pre == DEPTH) exp_ovf = 1'b1;
      else m_fifo.push_back(k);
    end

    @(posedge clk);
    #1;
    chk("valid", 32'(kif.valid), 32'(cur.size() != 0));
    if (cur.size() != 0) chk("data", 32'(kif.data), 32'(cur[0]));
    chk("overflow", 32'(kif.overflow), 32'(exp_ovf));
    if (kif.overflow) ovf_count++;
    if (kif.valid) vcount++;
  endtask

  task automatic do_reset(input int n, input logic s);
    reset = 1'b1;
    kif.kbd_strobe = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    m_fifo.delete();
    cur.delete();
    m_strobe = 1'b1;
    exp_ovf  = 1'b0;
    chk("rst_valid", 32'(kif.valid), 32'd0);
    chk("rst_data", 32'(kif.data), 32'h00);
    chk("rst_overflow", 32'(kif.overflow), 32'd0);
    reset = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    kif.kbd_strobe = 1'b0;
    kif.usb_kbd    = 8'h00;
    kif.ready      = 1'b0;
    do_reset(3, 1'b0);

    // Single ASCII key: one byte, valid after the second edge, one cycle wide.
    got.delete();
    vcount = 0;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h61, 1'b1);
    chk("s036_lat0", 32'(kif.valid), 32'd0);
    step(1'b0, 8'h61, 1'b1);
    chk("s036_lat1", 32'(kif.valid), 32'd1);
    chk("s036_data", 32'(kif.data), 32'h61);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    chk("s036_vcycles", 32'(vcount), 32'd1);
    exp_q = '{8'h61};
    check_stream("s036");

    // Cursor up becomes ESC 'A'.
    got.delete();
    step(1'b1, 8'h80, 1'b1);
    repeat (5) step(1'b0, 8'h00, 1'b1);
    exp_q = '{8'h1B, 8'h41};
    check_stream("s037");

    // Stall with left arrow and 'b' queued.
    got.delete();
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h83, 1'b0);
    step(1'b0, 8'h83, 1'b0);
    step(1'b1, 8'h62, 1'b0);
    step(1'b0, 8'h62, 1'b0);
    repeat (10) begin
      step(1'b0, 8'h00, 1'b0);
      chk("s038_hold", 32'(kif.data), 32'h1B);
    end
    repeat (6) step(1'b0, 8'h00, 1'b1);
    exp_q = '{8'h1B, 8'h44, 8'h62};
    check_stream("s038");

    // One key parks in the sequencer, then DEPTH+2 more arrive while stalled.
    got.delete();
    ovf_count = 0;
    step(1'b1, 8'h30, 1'b0);
    step(1'b0, 8'h30, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, 8'(8'h41 + i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
    end
    chk("s039_ovf_pulses", 32'(ovf_count), 32'd2);
    repeat (3 * DEPTH + 10) step(1'b0, 8'h00, 1'b1);
    exp_q.delete();
    exp_q.push_back(8'h30);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h41 + i));
    check_stream("s039");

    // Held strobe gives one event; an invalid code gives nothing.
    got.delete();
    ovf_count = 0;
    repeat (20) step(1'b1, 8'h41, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h90, 1'b1);
    repeat (5) step(1'b0, 8'h00, 1'b1);
    chk("s040_ovf_pulses", 32'(ovf_count), 32'd0);
    exp_q = '{8'h41};
    check_stream("s040");

    // Reset between ESC and 'A'; strobe stays high through reset release.
    got.delete();
    step(1'b1, 8'h80, 1'b1);
    step(1'b1, 8'h80, 1'b1);
    step(1'b1, 8'h80, 1'b1);
    chk("s041_second_pending", 32'(kif.data), 32'h41);
    do_reset(2, 1'b1);
    repeat (3) step(1'b1, 8'h80, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    chk("s041_valid_after", 32'(kif.valid), 32'd0);
    exp_q = '{8'h1B};
    check_stream("s041");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] k;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       k = 8'($urandom_range(8'h00, 8'h7F));
        1:       k = 8'($urandom_range(8'h80, 8'h87));
        2:       k = 8'($urandom_range(8'h88, 8'hFF));
        default: k = 8'($urandom_range(8'h20, 8'h7E));
      endcase
      step(1'($urandom_range(0, 1)), k, ($urandom_range(0, 3) != 0));
    end
    repeat (40) step(1'b0, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
